// File: rtl/edsac_word_receiver_if.sv
// edsac_word_receiver_if: pulse-train input and parallel word output bundle for the EDSAC word receiver
// in_sig/frame_start flow master->slave; word, word_valid, frame_err, sync_err, weak_bit, locked flow slave->master
interface edsac_word_receiver_if #(parameter int WORD_BITS = 35);
  logic in_sig;
  logic frame_start;
  logic [WORD_BITS-1:0] word;
  logic word_valid;
  logic frame_err;
  logic sync_err;
  logic weak_bit;
  logic locked;
  modport master (output in_sig, frame_start, input word, word_valid, frame_err, sync_err, weak_bit, locked);
  modport slave (input in_sig, frame_start, output word, word_valid, frame_err, sync_err, weak_bit, locked);
endinterface

// File: rtl/edsac_word_receiver.sv
// edsac_word_receiver: recovers 35-bit EDSAC words from the delay-line carrier burst train
// clk/rst: 81 MHz clock, async active-high reset; bus.in_sig: async modulated input; bus.frame_start: slot-0 restart
// bus.word/word_valid: received word and its strobe; bus.frame_err/sync_err/weak_bit: error strobes; bus.locked: in RUN
module edsac_word_receiver #(
  parameter int SLOT_CYCLES = 162,
  parameter int HOLD_CYCLES = 9,
  parameter int MIN_PULSES = 8,
  parameter int SAMPLE_CYCLE = 120,
  parameter int RESYNC_WIN = 8,
  parameter int WORD_BITS = 35
) (
  input logic clk,
  input logic rst,
  edsac_word_receiver_if.slave bus
);
  localparam int PW = $clog2(SLOT_CYCLES);
  localparam int SW = $clog2(WORD_BITS + 1);
  localparam int HW = $clog2(HOLD_CYCLES + 1);
  localparam logic [PW-1:0] PH_LAST = PW'(SLOT_CYCLES - 1);
  localparam logic [PW-1:0] PH_SAMPLE = PW'(SAMPLE_CYCLE);
  localparam logic [PW-1:0] PH_EARLY = PW'(SLOT_CYCLES - RESYNC_WIN);
  localparam logic [PW-1:0] PH_LATE = PW'(RESYNC_WIN);
  localparam logic [SW-1:0] SL_SPACE = SW'(WORD_BITS);
  localparam logic [HW-1:0] HOLD_LOAD = HW'(HOLD_CYCLES);
  localparam logic [3:0] MINP = 4'(MIN_PULSES);
  typedef enum logic {IDLE, RUN} state_t;
  state_t state;
  logic s1, s2, s2_d;
  logic [HW-1:0] hold;
  logic [3:0] cnt;
  logic [PW-1:0] phase;
  logic [SW-1:0] slot;
  logic [WORD_BITS-1:0] shift;
  logic edge_det, env_rise, bit_one, sample, wrap, early, late;
  logic [SW-1:0] slot_next;
  // env_rise marks the edge that will lift an idle envelope, so the burst's first edge is counted in the same cycle
  always_comb begin
    edge_det = s2 & ~s2_d;
    env_rise = edge_det & (hold == '0);
    bit_one = cnt >= MINP;
    sample = (state == RUN) & (phase == PH_SAMPLE);
    wrap = phase == PH_LAST;
    early = phase >= PH_EARLY;
    late = phase <= PH_LATE;
    slot_next = (slot == SL_SPACE) ? '0 : slot + 1'b1;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s2_d <= 1'b0;
      hold <= '0;
      cnt <= '0;
      state <= IDLE;
      phase <= '0;
      slot <= '0;
      shift <= '0;
      bus.word <= '0;
      bus.word_valid <= 1'b0;
      bus.frame_err <= 1'b0;
      bus.sync_err <= 1'b0;
      bus.weak_bit <= 1'b0;
      bus.locked <= 1'b0;
    end else begin
      s1 <= bus.in_sig;
      s2 <= s1;
      s2_d <= s2;
      hold <= edge_det ? HOLD_LOAD : (hold != '0 ? hold - 1'b1 : hold);
      cnt <= env_rise ? 4'd1 : (sample ? 4'd0 : (edge_det && cnt != 4'hf ? cnt + 1'b1 : cnt));
      bus.word_valid <= 1'b0;
      bus.frame_err <= 1'b0;
      bus.sync_err <= 1'b0;
      bus.weak_bit <= 1'b0;
      if (state == IDLE) begin
        phase <= '0;
        slot <= '0;
        if (bus.frame_start || env_rise) begin
          state <= RUN;
          bus.locked <= 1'b1;
          shift <= '0;
        end
      end else if (bus.frame_start) begin
        phase <= '0;
        slot <= '0;
        shift <= '0;
      end else if (env_rise && early) begin
        // a slightly early burst is taken as the start of the next slot
        phase <= '0;
        slot <= slot_next;
      end else if (env_rise && late) begin
        phase <= '0;
      end else if (env_rise) begin
        state <= IDLE;
        bus.locked <= 1'b0;
        bus.sync_err <= 1'b1;
        phase <= '0;
        slot <= '0;
        shift <= '0;
      end else begin
        phase <= wrap ? '0 : phase + 1'b1;
        if (wrap)
          slot <= slot_next;
        if (sample) begin
          bus.weak_bit <= (cnt != 4'd0) && !bit_one;
          if (slot == SL_SPACE) begin
            bus.word <= shift;
            bus.word_valid <= 1'b1;
            bus.frame_err <= bit_one;
          end else
            shift <= {shift[WORD_BITS-2:0], bit_one};
        end
      end
    end
  end
endmodule

// File: tb/tb_edsac_word_receiver.sv
// tb_edsac_word_receiver: directed bench for edsac_word_receiver
module tb_edsac_word_receiver;
  logic clk = 1'b0;
  logic rst = 1'b1;
  edsac_word_receiver_if #(.WORD_BITS(35)) bus();
  edsac_word_receiver #(.WORD_BITS(35)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #6 clk = ~clk;
  typedef struct {
    logic [34:0] val;
    bit jit;
    int weak_slot;
    bit space_burst;
    logic [34:0] exp_word;
    bit exp_ferr;
    int exp_weak;
  } vec_t;
  int total = 0, bad = 0;
  int n_valid = 0, n_ferr = 0, n_sync = 0, n_weak = 0, n_long = 0, n_solo = 0;
  int b_valid, b_ferr, b_sync, b_weak;
  logic [34:0] last_word = '0;
  logic [3:0] prev = '0;
  always @(negedge clk) begin
    if (bus.word_valid) begin
      n_valid++;
      last_word = bus.word;
    end
    if (bus.frame_err) n_ferr++;
    if (bus.sync_err) n_sync++;
    if (bus.weak_bit) n_weak++;
    if (bus.frame_err && !bus.word_valid) n_solo++;
    if (({bus.word_valid, bus.frame_err, bus.sync_err, bus.weak_bit} & prev) != 4'd0) n_long++;
    prev = {bus.word_valid, bus.frame_err, bus.sync_err, bus.weak_bit};
  end
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic snap;
    b_valid = n_valid;
    b_ferr = n_ferr;
    b_sync = n_sync;
    b_weak = n_weak;
  endtask
  task automatic slot(input int np, input int pre);
    cyc(pre);
    repeat (np) begin
      bus.in_sig = 1'b1;
      cyc(3);
      bus.in_sig = 1'b0;
      cyc(3);
    end
    cyc(162 - pre - 6 * np);
  endtask
  task automatic send_word(input logic [34:0] val, input bit jit, input int ws, input bit sb);
    for (int i = 0; i < 36; i++) begin
      bit b;
      int j;
      b = (i < 35) ? val[34 - i] : sb;
      j = jit ? int'($urandom_range(6)) - 3 : 0;
      slot((i == ws) ? 5 : (b ? 12 : 0), 3 + j);
    end
  endtask
  initial begin
    vec_t vecs[8];
    int lat;
    for (int i = 0; i < 6; i++) begin
      logic [34:0] v;
      v = 35'({$urandom(), $urandom()});
      vecs[i] = '{v, 1'b1, -1, 1'b0, v, 1'b0, 0};
    end
    vecs[6] = '{35'h5_5555_5555, 1'b0, 2, 1'b0, 35'h4_5555_5555, 1'b0, 1};
    vecs[7] = '{35'h4_0000_0001, 1'b0, -1, 1'b1, 35'h4_0000_0001, 1'b1, 0};
    bus.in_sig = 1'b0;
    bus.frame_start = 1'b0;
    cyc(4);
    chk("reset word", bus.word, 0);
    chk("reset word_valid", bus.word_valid, 0);
    chk("reset locked", bus.locked, 0);
    rst = 1'b0;
    cyc(5);
    snap;
    send_word('1, 1'b0, -1, 1'b0);
    chk("ones valid count", n_valid - b_valid, 1);
    chk("ones word", last_word, 35'h7_FFFF_FFFF);
    chk("ones frame_err", n_ferr - b_ferr, 0);
    chk("ones weak", n_weak - b_weak, 0);
    chk("ones locked", bus.locked, 1);
    for (int i = 0; i < 8; i++) begin
      snap;
      send_word(vecs[i].val, vecs[i].jit, vecs[i].weak_slot, vecs[i].space_burst);
      chk($sformatf("vec%0d valid count", i), n_valid - b_valid, 1);
      chk($sformatf("vec%0d word", i), last_word, vecs[i].exp_word);
      chk($sformatf("vec%0d frame_err", i), n_ferr - b_ferr, vecs[i].exp_ferr);
      chk($sformatf("vec%0d weak", i), n_weak - b_weak, vecs[i].exp_weak);
      chk($sformatf("vec%0d sync_err", i), n_sync - b_sync, 0);
      chk($sformatf("vec%0d locked", i), bus.locked, 1);
    end
    snap;
    for (int i = 0; i < 10; i++) slot(12, 3);
    slot(5, 84);
    chk("phase80 sync_err", n_sync - b_sync, 1);
    chk("phase80 locked", bus.locked, 0);
    cyc(26 * 162);
    chk("phase80 no word", n_valid - b_valid, 0);
    chk("phase80 still idle", bus.locked, 0);
    for (int i = 0; i < 17; i++) slot(12, 3);
    cyc(20);
    chk("pre-reset locked", bus.locked, 1);
    #2 rst = 1'b1;
    #1;
    chk("async reset word", bus.word, 0);
    chk("async reset word_valid", bus.word_valid, 0);
    chk("async reset frame_err", bus.frame_err, 0);
    chk("async reset sync_err", bus.sync_err, 0);
    chk("async reset weak_bit", bus.weak_bit, 0);
    chk("async reset locked", bus.locked, 0);
    bus.in_sig = 1'b0;
    cyc(5);
    rst = 1'b0;
    cyc(20);
    snap;
    send_word('1, 1'b0, -1, 1'b0);
    chk("post-reset valid count", n_valid - b_valid, 1);
    chk("post-reset word", last_word, 35'h7_FFFF_FFFF);
    chk("post-reset frame_err", n_ferr - b_ferr, 0);
    bus.frame_start = 1'b1;
    @(posedge clk);
    #1 bus.frame_start = 1'b0;
    snap;
    lat = -1;
    for (int k = 1; k <= 6000; k++) begin
      @(posedge clk);
      #1;
      if (bus.word_valid) begin
        lat = k;
        break;
      end
    end
    chk("empty latency", lat, 35 * 162 + 121);
    chk("empty word", bus.word, 0);
    cyc(1);
    chk("empty valid one cycle", bus.word_valid, 0);
    chk("empty frame_err", n_ferr - b_ferr, 0);
    chk("empty sync_err", n_sync - b_sync, 0);
    chk("empty weak", n_weak - b_weak, 0);
    chk("strobe longer than one cycle", n_long, 0);
    chk("frame_err without word_valid", n_solo, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
